// File: rtl/storage_sequencer_pkg.sv
// storage_sequencer_pkg: shared widths, capture offset, default depth and FSM states
package storage_sequencer_pkg;
  localparam int WORD_W = 12;
  localparam int CAP_OFFSET = 10;
  localparam int SEQ_DEPTH = 10;
  typedef enum logic [1:0] {IDLE, ACQ, PREP, READ} state_t;
endpackage

// File: rtl/storage_sequencer_measure_timebase.sv
// measure_timebase: cnt_point/cnt_measure generation and the per-period capture strobe
module measure_timebase
  import storage_sequencer_pkg::*;
#(
  parameter int POINTS    = 10,
  parameter int MEASURES  = 100,
  parameter int POINT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_run,
  input  logic        i_freeze,
  output logic [10:0] o_cnt_point,
  output logic [16:0] o_cnt_measure,
  output logic        o_capture
);
  localparam logic [16:0] CAP_AT  = 17'(2 * POINTS + CAP_OFFSET);
  localparam logic [10:0] PT_LAST = 11'(POINT_DIV - 1);
  localparam logic [16:0] M_LAST  = 17'(MEASURES - 1);
  logic [10:0] r_cnt_point;
  logic [16:0] r_cnt_measure;
  logic        w_wrap;
  assign w_wrap = r_cnt_point == PT_LAST;
  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_cnt_point   <= '0;
      r_cnt_measure <= '0;
    end else begin
      r_cnt_point <= w_wrap ? '0 : r_cnt_point + 11'd1;
      if (w_wrap) r_cnt_measure <= (r_cnt_measure == M_LAST) ? '0 : r_cnt_measure + 17'd1;
    end
  end
  // counters sit at zero while idle, so the strobe cannot fire there
  assign o_capture     = !i_freeze && r_cnt_measure == CAP_AT && r_cnt_point == '0;
  assign o_cnt_point   = r_cnt_point;
  assign o_cnt_measure = r_cnt_measure;
endmodule

// File: rtl/storage_sequencer.sv
// storage_sequencer: acquisition/readout FSM with frame-history readout mux
module storage_sequencer
  import storage_sequencer_pkg::*;
#(
  parameter int POINTS    = 10,
  parameter int MEASURES  = 100,
  parameter int POINT_DIV = 4,
  parameter int DEPTH     = SEQ_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             rd_req,
  input  logic [WORD_W*POINTS*DEPTH-1:0]   storage,
  output logic [16:0]                      cnt_measure,
  output logic [10:0]                      cnt_point,
  output logic [3:0]                       cnt_save,
  output logic                             switch,
  output logic [WORD_W-1:0]                rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic                             rd_last,
  output logic                             busy
);
  localparam int IDX_W = $clog2(POINTS * DEPTH + 1);
  state_t             r_state;
  logic               r_stop_pend;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_words;
  logic [3:0]         r_cnt_save;
  logic               r_switch;
  logic               r_rd_valid;
  logic               r_rd_last;
  logic [WORD_W-1:0]  r_rd_data;
  logic               w_capture;
  logic               w_hs;
  logic               w_done;
  logic               w_run;
  logic [3:0]         w_save_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_sel;
  logic [WORD_W-1:0]  w_word;
  assign w_hs       = r_rd_valid && rd_ready;
  assign w_done     = r_state == READ && w_hs && r_rd_last;
  assign w_run      = (r_state == ACQ && !stop) || r_state == PREP ||
                      (r_state == READ && !(w_done && (r_stop_pend || stop)));
  assign w_save_nxt = (w_capture && r_cnt_save != 4'(DEPTH)) ? r_cnt_save + 4'd1 : r_cnt_save;
  assign w_idx_nxt  = r_idx + IDX_W'(1);
  // word index maps straight onto the flat history: frame-major, point-minor
  assign w_sel      = (r_state == PREP) ? '0 : w_idx_nxt;
  assign w_word     = storage[WORD_W * int'(w_sel) +: WORD_W];
  measure_timebase #(
    .POINTS   (POINTS),
    .MEASURES (MEASURES),
    .POINT_DIV(POINT_DIV)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .i_run        (w_run),
    .i_freeze     (r_switch),
    .o_cnt_point  (cnt_point),
    .o_cnt_measure(cnt_measure),
    .o_capture    (w_capture)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_stop_pend <= 1'b0;
      r_idx       <= '0;
      r_words     <= '0;
      r_cnt_save  <= '0;
      r_switch    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start && !stop) begin
          r_state     <= ACQ;
          r_cnt_save  <= '0;
          r_stop_pend <= 1'b0;
        end
        ACQ: if (stop) begin
          r_state    <= IDLE;
          r_cnt_save <= '0;
        end else begin
          r_cnt_save <= w_save_nxt;
          if (rd_req && r_cnt_save != '0) begin
            r_state  <= PREP;
            r_switch <= 1'b1;
            r_idx    <= '0;
            r_words  <= IDX_W'(int'(w_save_nxt) * POINTS);
          end
        end
        PREP: begin
          r_stop_pend <= r_stop_pend | stop;
          r_state     <= READ;
          r_rd_valid  <= 1'b1;
          r_rd_data   <= w_word;
          r_rd_last   <= r_words == IDX_W'(1);
        end
        READ: begin
          r_stop_pend <= r_stop_pend | stop;
          if (w_done) begin
            r_state     <= (r_stop_pend || stop) ? IDLE : ACQ;
            r_cnt_save  <= (r_stop_pend || stop) ? '0 : r_cnt_save;
            r_stop_pend <= 1'b0;
            r_switch    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_idx       <= '0;
          end else if (w_hs) begin
            r_idx     <= w_idx_nxt;
            r_rd_data <= w_word;
            r_rd_last <= (r_idx + IDX_W'(2)) == r_words;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign cnt_save = r_cnt_save;
  assign switch   = r_switch;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign busy     = r_state != IDLE;
endmodule

// File: tb/tb_storage_sequencer.sv
// tb_storage_sequencer: randomized checks of storage_sequencer against a time-index reference model
module tb_storage_sequencer;
  localparam int P    = 10;
  localparam int MS   = 100;
  localparam int PD   = 4;
  localparam int D    = 10;
  localparam int CAPT = (2 * P + 10) * PD;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               rd_req = 1'b0;
  logic               rd_ready = 1'b0;
  logic [12*P*D-1:0]  stor = '0;
  logic [16:0]        cnt_measure;
  logic [10:0]        cnt_point;
  logic [3:0]         cnt_save;
  logic               switch;
  logic [11:0]        rd_data;
  logic               rd_valid;
  logic               rd_last;
  logic               busy;
  int                 n_chk = 0;
  int                 n_err = 0;
  int                 t = 0;
  int                 save = 0;
  bit                 mdl_run = 1'b0;
  bit                 mdl_frozen = 1'b0;
  always #5 clk = ~clk;
  storage_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rd_req(rd_req),
    .storage(stor), .cnt_measure(cnt_measure), .cnt_point(cnt_point),
    .cnt_save(cnt_save), .switch(switch), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // model time t = clocks since start; captures happen at t = CAPT mod the period
  task automatic tick();
    if (mdl_run && !mdl_frozen && t % (MS * PD) == CAPT && save < D) save++;
    if (mdl_run) t++;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt();
    chk("cnt_measure", cnt_measure, mdl_run ? 32'((t / PD) % MS) : 32'd0);
    chk("cnt_point", cnt_point, mdl_run ? 32'(t % PD) : 32'd0);
    chk("cnt_save", cnt_save, save);
    chk("busy", busy, mdl_run);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_measure"}, cnt_measure, 0);
    chk({tag, "_point"}, cnt_point, 0);
    chk({tag, "_save"}, cnt_save, 0);
    chk({tag, "_switch"}, switch, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_last"}, rd_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic fill_storage();
    for (int i = 0; i < P * D; i++) stor[12*i +: 12] = 12'($urandom);
  endtask
  task automatic run_until(input int target);
    while (t < target) begin
      tick();
      chk_cnt();
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mdl_run = 1'b1;
    mdl_frozen = 1'b0;
    t = 0;
    save = 0;
    chk_cnt();
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mdl_run = 1'b0;
    t = 0;
    save = 0;
    chk_cnt();
  endtask
  task automatic do_read(input int mode, input int stop_at, input int rst_at);
    int words, n, k;
    bit r, stop_sent, done;
    bit [3:0] pat;
    pat = 4'b1001;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    mdl_frozen = 1'b1;
    words = save * P;
    chk("switch_rise", switch, 1);
    chk("prep_valid", rd_valid, 0);
    chk_cnt();
    n = 0;
    k = 0;
    done = 1'b0;
    stop_sent = 1'b0;
    while (!done && k < 4000) begin
      if (k > 0 && n == rst_at) begin
        rst = 1'b1;
        rd_ready = 1'b1;
        tick();
        mdl_run = 1'b0;
        mdl_frozen = 1'b0;
        t = 0;
        save = 0;
        chk_zero("rst_mid_read");
        rst = 1'b0;
        repeat (5) begin
          tick();
          chk("post_rst_valid", rd_valid, 0);
          chk_cnt();
        end
        rd_ready = 1'b0;
        return;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : 1'($urandom_range(0, 1));
      rd_ready = r;
      if (n == stop_at && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      tick();
      stop = 1'b0;
      if (k > 0 && r) n++;
      k++;
      if (n == words) begin
        done = 1'b1;
        mdl_frozen = 1'b0;
        if (stop_sent) begin
          mdl_run = 1'b0;
          t = 0;
          save = 0;
        end
        chk("switch_fall", switch, 0);
        chk("valid_fall", rd_valid, 0);
        chk_cnt();
      end else begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, stor[12*n +: 12]);
        chk("rd_last", rd_last, n == words - 1);
        chk("switch_hold", switch, 1);
        chk_cnt();
      end
    end
    rd_ready = 1'b0;
    if (!done) chk("read_timeout", 0, 1);
  endtask
  initial begin
    fill_storage();
    repeat (3) tick();
    chk_zero("in_rst");
    rst = 1'b0;
    tick();
    chk_zero("after_rst");
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    do_start();
    run_until(1000);
    chk("save_after_3", cnt_save, 3);
    run_until(12 * MS * PD + 1);
    chk("save_saturated", cnt_save, D);
    do_stop();
    do_start();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("req_ignored_empty", switch, 0);
    chk_cnt();
    run_until(700);
    chk("save_before_read", cnt_save, 2);
    do_read(0, -1, -1);
    run_until(MS * PD * 2 + CAPT);
    do_read(1, -1, -1);
    chk("capture_on_req", save, 3);
    chk("capture_on_req_dut", cnt_save, 3);
    do_stop();
    fill_storage();
    do_start();
    run_until(700 + int'($urandom_range(0, 100)));
    do_read(2, 5, -1);
    tick();
    chk_cnt();
    fill_storage();
    do_start();
    run_until(700);
    do_read(2, -1, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/storage_sequencer.md
STORAGE_SEQUENCER -- requirements
Module: storage_sequencer

Interface
REQ-001 SHALL have parameter POINTS, default 10: points per frame.
REQ-002 SHALL have parameter MEASURES, default 100: cnt_measure period; must exceed 2*POINTS+10.
REQ-003 SHALL have parameter POINT_DIV, default 4: clocks per cnt_measure step.
REQ-004 SHALL have parameter DEPTH, default 10: number of frames held in storage.
REQ-005 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port rst  in  1  reset; synchronous and active-high.
REQ-007 Port start  in  1  single-cycle pulse that arms acquisition.
REQ-008 Port stop  in  1  single-cycle pulse that halts acquisition.
REQ-009 Port rd_req  in  1  host readout request pulse.
REQ-010 Port storage  in  12*POINTS*DEPTH  frame history; frame f, point p at bits [12*POINTS*f+12*p +: 12]; f=0 is newest.
REQ-011 Port cnt_measure  out  17  measurement-phase counter.
REQ-012 Port cnt_point  out  11  sub-step counter.
REQ-013 Port cnt_save  out  4  frames captured since start, saturating.
REQ-014 Port switch  out  1  high freezes storage (capture suppressed).
REQ-015 Port rd_data  out  12  readout word; rd_valid out 1; rd_ready in 1; rd_last out 1.
REQ-016 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, ACQ, PREP and READ.
- IDLE->ACQ on start.
- ACQ->PREP on rd_req while cnt_save>0.
- PREP->READ after one cycle.
- READ->ACQ, or READ->IDLE if stop is pending, after the rd_last handshake.
- ACQ->IDLE on stop.
REQ-018 In IDLE, counters SHALL hold 0. On start, cnt_measure, cnt_point and cnt_save SHALL clear to 0.
REQ-019 In ACQ, PREP and READ, cnt_point SHALL count 0..POINT_DIV-1 and wrap. cnt_measure SHALL increment when cnt_point wraps, and wrap MEASURES-1->0.
REQ-020 Capture condition is cnt_measure==2*POINTS+10 && cnt_point==0 && !switch. It lasts exactly one clock per cnt_measure period.
REQ-021 cnt_save SHALL increment on each capture condition and saturate at DEPTH.
REQ-022 switch SHALL be registered, high in PREP and READ, low otherwise. It rises the clock after rd_req is accepted.
REQ-023 A capture in the cycle rd_req is accepted SHALL complete and SHALL be counted and read out.
REQ-024 rd_req SHALL be ignored:
- when cnt_save==0;
- in IDLE, PREP and READ.
REQ-025 READ SHALL stream cnt_save*POINTS words in order frame 0..cnt_save-1, then point 0..POINTS-1 within each frame. The word count is latched on entry to PREP.
REQ-026 rd_valid SHALL first assert on entry to READ. rd_data, rd_last and rd_valid SHALL stay stable while rd_valid && !rd_ready. The index SHALL advance only on a rd_valid && rd_ready handshake.
REQ-027 rd_last SHALL be high only with the final word. switch and rd_valid SHALL drop the clock after the final handshake.
REQ-028 stop in PREP or READ SHALL be latched. The readout SHALL complete before the move to IDLE.
REQ-029 start outside IDLE SHALL be ignored. Simultaneous start and stop in IDLE: stop SHALL win and the block stays in IDLE.

Reset
REQ-030 rst SHALL force IDLE and clear the pending-stop flag and word index.
REQ-031 rst SHALL drive all outputs to 0.
REQ-032 rst SHALL override every other input, including mid-READ. No further words are issued after reset.

Structure
REQ-033 A shared package SHALL hold:
- word width 12;
- capture offset 10;
- DEPTH;
- the state enumeration.
REQ-034 The counters SHALL live in one sub-module, measure_timebase: cnt_point/cnt_measure generation plus capture strobe. The readout mux and FSM SHALL live in the top.

Verification
REQ-035 Stimulus: reset, then start, with defaults. Response: cnt_measure steps every 4 clocks, wraps 99->0; one capture strobe at cnt_measure=30 per 400 clocks.
REQ-036 Stimulus: run 12 periods. Response: cnt_save reads 3 after 3 captures; saturates at 10 after 12.
REQ-037 Stimulus: rd_req with cnt_save=2, rd_ready tied high. Response: switch high the next clock; 20 words, frame 0 point 0 first; rd_last on word 20; switch low one clock later.
REQ-038 Stimulus: rd_ready toggled 1-0-0-1 during READ. Response: rd_data and rd_valid held while stalled; no word skipped or repeated.
REQ-039 Stimulus: rd_req in the capture cycle (cnt_measure=30, cnt_point=0). Response: cnt_save increments; readout includes the new frame.
REQ-040 Stimulus: stop at word 5 of 20, then rst mid-READ on a second run. Response: first run completes 20 words, then IDLE; after rst all outputs are 0 the next clock.
